te_pwr_domain_seq: RTL and testbench

//  Power/isolation sequencer for the two timing-engine consumer domains (D0=PD_M2, D1=PD_M3) fed from
//  the always-more-on PD_M1 producer. Shares one sequencer FSM between the two domain requests.
//  Per domain: power switch on -> settle -> release isolation -> wait pllSettled -> enable radio;

---
 rtl/te_pwr_seq_pkg.sv | 18 +
 rtl/te_pwr_rr_arb2.sv | 17 +
 rtl/te_pwr_domain_seq.sv | 101 ++++++++++
 tb/tb_te_pwr_domain_seq.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/te_pwr_seq_pkg.sv
// te_pwr_seq_pkg: shared state encoding, domain indices and sizing helper for the domain sequencer
package te_pwr_seq_pkg;
  localparam int D_M2 = 0;
  localparam int D_M3 = 1;
  localparam int NUM_DOM = 2;
  typedef enum logic [2:0] {
    IDLE,
    PWR_UP,
    ISO_OFF,
    WAIT_PLL,
    DIS_RADIO,
    ISO_ON,
    PWR_DOWN
  } te_pwr_state_e;
  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/te_pwr_rr_arb2.sv
// te_pwr_rr_arb2: two-way round-robin arbiter; the pointer names the preferred domain on a tie
module te_pwr_rr_arb2
  import te_pwr_seq_pkg::*;
(
  input  logic               i_ck,
  input  logic               i_arst,
  input  logic [NUM_DOM-1:0] i_req,
  input  logic               i_advance,
  output logic [NUM_DOM-1:0] o_gnt
);
  logic r_rr_ptr;
  always_comb o_gnt = (&i_req) ? (r_rr_ptr ? 2'b10 : 2'b01) : i_req;
  always_ff @(posedge i_ck) begin
    if (i_arst) r_rr_ptr <= 1'b0;
    else if (i_advance && |o_gnt) r_rr_ptr <= ~o_gnt[1];
  end
endmodule

// File: rtl/te_pwr_domain_seq.sv
// te_pwr_domain_seq: one shared FSM sequencing power, isolation and radio enable for two consumer domains
module te_pwr_domain_seq
  import te_pwr_seq_pkg::*;
#(
  parameter int SETTLE_CYCLES = 16,
  parameter int PLL_TIMEOUT   = 255
) (
  input  logic       i_ck,
  input  logic       i_arst,
  input  logic [1:0] i_pwr_req,
  input  logic       i_pll_settled,
  input  logic [1:0] i_err_clr,
  output logic [1:0] o_pwr_en,
  output logic [1:0] o_isolate,
  output logic [1:0] o_radio_enable,
  output logic [1:0] o_pwr_ack,
  output logic       o_busy,
  output logic [1:0] o_timeout_err
);
  localparam int CNT_W = $clog2(max2(SETTLE_CYCLES, PLL_TIMEOUT) + 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] PLL_LAST = CNT_W'(PLL_TIMEOUT - 1);
  te_pwr_state_e r_state, w_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic       r_sel, r_busy;
  logic [1:0] r_up, r_pwr_en, r_iso, r_radio, r_terr;
  logic [1:0] w_want_up, w_want_dn, w_elig, w_gnt;
  logic       w_idx, w_req_sel, w_timeout;
  assign w_want_up = i_pwr_req & ~r_up & ~r_terr;
  assign w_want_dn = ~i_pwr_req & r_up;
  assign w_elig    = w_want_up | w_want_dn;
  assign w_req_sel = i_pwr_req[r_sel];
  assign w_idx     = (r_state == IDLE) ? w_gnt[1] : r_sel;
  te_pwr_rr_arb2 u_arb (
    .i_ck     (i_ck),
    .i_arst   (i_arst),
    .i_req    (w_elig),
    .i_advance(r_state == IDLE),
    .o_gnt    (w_gnt)
  );
  always_comb begin
    w_nxt = r_state;
    w_timeout = 1'b0;
    case (r_state)
      IDLE:      w_nxt = ~|w_elig ? IDLE : (|(w_gnt & w_want_up)) ? PWR_UP : DIS_RADIO;
      PWR_UP:    w_nxt = ~w_req_sel ? ISO_ON : (r_cnt == SETTLE_LAST) ? ISO_OFF : PWR_UP;
      ISO_OFF:   w_nxt = w_req_sel ? WAIT_PLL : ISO_ON;
      WAIT_PLL: begin
        w_timeout = w_req_sel & ~i_pll_settled & (r_cnt == PLL_LAST);
        w_nxt = (~w_req_sel | w_timeout) ? ISO_ON : i_pll_settled ? IDLE : WAIT_PLL;
      end
      DIS_RADIO: w_nxt = ISO_ON;
      ISO_ON:    w_nxt = PWR_DOWN;
      PWR_DOWN:  w_nxt = (r_cnt == SETTLE_LAST) ? IDLE : PWR_DOWN;
      default:   w_nxt = IDLE;
    endcase
  end
  always_ff @(posedge i_ck) begin
    if (i_arst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_nxt;
      r_cnt   <= (w_nxt != r_state) ? '0 : (&r_cnt ? r_cnt : r_cnt + 1'b1);
    end
  end
  // Each output bit only moves on entry to the state that owns it, and only for the active domain.
  always_ff @(posedge i_ck) begin
    if (i_arst) begin
      r_sel    <= 1'b0;
      r_busy   <= 1'b0;
      r_up     <= '0;
      r_pwr_en <= '0;
      r_iso    <= 2'b11;
      r_radio  <= '0;
      r_terr   <= '0;
    end else begin
      r_busy <= (w_nxt != IDLE);
      r_terr <= (r_terr & ~i_err_clr) | ({1'b0, w_timeout} << r_sel);
      if (r_state == IDLE && w_nxt != IDLE) r_sel <= w_gnt[1];
      if (r_state == IDLE && w_nxt == PWR_UP) r_pwr_en[w_idx] <= 1'b1;
      if (r_state == ISO_ON) r_pwr_en[w_idx] <= 1'b0;
      if (w_nxt == ISO_OFF) r_iso[w_idx] <= 1'b0;
      if (w_nxt == ISO_ON) r_iso[w_idx] <= 1'b1;
      if (w_nxt == DIS_RADIO) begin
        r_radio[w_idx] <= 1'b0;
        r_up[w_idx]    <= 1'b0;
      end
      if (r_state == WAIT_PLL && w_nxt == IDLE) begin
        r_radio[w_idx] <= 1'b1;
        r_up[w_idx]    <= 1'b1;
      end
    end
  end
  assign o_pwr_en       = r_pwr_en;
  assign o_isolate      = r_iso;
  assign o_radio_enable = r_radio;
  assign o_pwr_ack      = r_radio;
  assign o_busy         = r_busy;
  assign o_timeout_err  = r_terr;
endmodule

// File: tb/tb_te_pwr_domain_seq.sv
// tb_te_pwr_domain_seq: sequence-level reference model feeding a scoreboard of expected output changes
module tb_te_pwr_domain_seq;
  localparam int S = 4;
  localparam int PT = 8;
  localparam logic [10:0] RST_V = 11'b0_00_00_00_11_00;
  logic ck = 1'b0, arst = 1'b1, pll = 1'b0;
  logic [1:0] req = '0, clr = '0;
  logic [1:0] o_pwr, o_iso, o_radio, o_ack, o_terr;
  logic o_busy;
  te_pwr_domain_seq #(.SETTLE_CYCLES(S), .PLL_TIMEOUT(PT)) dut (
    .i_ck(ck), .i_arst(arst), .i_pwr_req(req), .i_pll_settled(pll), .i_err_clr(clr),
    .o_pwr_en(o_pwr), .o_isolate(o_iso), .o_radio_enable(o_radio), .o_pwr_ack(o_ack),
    .o_busy(o_busy), .o_timeout_err(o_terr)
  );
  always #5 ck = ~ck;
  typedef struct {int cyc; logic [10:0] v;} exp_t;
  exp_t q[$];
  int compared = 0, mismatched = 0;
  logic [1:0] m_pwr = '0, m_iso = 2'b11, m_radio = '0, m_up = '0, m_err = '0, pre_err = '0;
  logic m_busy = 1'b0, m_rr = 1'b0;
  logic [10:0] m_last = RST_V;
  int mk = 0;
  function automatic logic [10:0] snap_m();
    return {m_busy, m_err, m_radio, m_radio, m_iso, m_pwr};
  endfunction
  task automatic emit();
    if (snap_m() !== m_last) begin
      q.push_back('{mk, snap_m()});
      m_last = snap_m();
    end
  endtask
  // Publishes the state reached at the previous edge, then advances to the next edge.
  task automatic tick(output bit r);
    emit();
    @(posedge ck);
    mk++;
    r = arst;
    pre_err = m_err;
    if (r) begin
      m_pwr = '0; m_iso = 2'b11; m_radio = '0; m_up = '0; m_err = '0; m_busy = 1'b0; m_rr = 1'b0;
    end else m_err = m_err & ~clr;
  endtask
  task automatic down_tail(input int d, output bit r);
    tick(r); if (r) return;
    m_pwr[d] = 1'b0;
    for (int i = 1; i <= S; i++) begin tick(r); if (r) return; end
    m_busy = 1'b0;
  endtask
  task automatic up_seq(input int d, output bit r);
    m_pwr[d] = 1'b1; m_busy = 1'b1;
    for (int i = 1; i <= S; i++) begin
      tick(r); if (r) return;
      if (!req[d]) begin m_iso[d] = 1'b1; down_tail(d, r); return; end
    end
    m_iso[d] = 1'b0;
    tick(r); if (r) return;
    if (!req[d]) begin m_iso[d] = 1'b1; down_tail(d, r); return; end
    for (int j = 1; j <= PT; j++) begin
      tick(r); if (r) return;
      if (!req[d]) begin m_iso[d] = 1'b1; down_tail(d, r); return; end
      if (pll) begin m_radio[d] = 1'b1; m_up[d] = 1'b1; m_busy = 1'b0; return; end
    end
    m_err[d] = 1'b1; m_iso[d] = 1'b1;
    down_tail(d, r);
  endtask
  task automatic dn_seq(input int d, output bit r);
    m_radio[d] = 1'b0; m_up[d] = 1'b0; m_busy = 1'b1;
    tick(r); if (r) return;
    m_iso[d] = 1'b1;
    down_tail(d, r);
  endtask
  initial begin
    bit r;
    logic [1:0] wu, el;
    int d;
    forever begin
      tick(r);
      if (r) continue;
      wu = req & ~m_up & ~pre_err;
      el = wu | (~req & m_up);
      if (el == 2'b00) continue;
      d = (el == 2'b11) ? int'(m_rr) : (el[1] ? 1 : 0);
      m_rr = (d == 0);
      if (wu[d]) up_seq(d, r); else dn_seq(d, r);
    end
  end
  int n = 0;
  logic [10:0] d_last = RST_V, cur;
  exp_t e;
  always @(negedge ck) begin
    n++;
    cur = {o_busy, o_terr, o_ack, o_radio, o_iso, o_pwr};
    while (q.size() > 0 && q[0].cyc < n) begin
      compared++; mismatched++;
      $display("FAIL missed_change cyc=%0d got %b required %b", q[0].cyc, cur, q[0].v);
      void'(q.pop_front());
    end
    if (cur !== d_last) begin
      compared++;
      if (q.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_change cyc=%0d got %b required %b", n, cur, d_last);
      end else begin
        e = q.pop_front();
        if (e.cyc != n || e.v !== cur) begin
          mismatched++;
          $display("FAIL output_change cyc=%0d got %b required %b at cyc %0d", n, cur, e.v, e.cyc);
        end
      end
      d_last = cur;
    end
    for (int i = 0; i < 2; i++) begin
      compared++;
      if ((o_radio[i] && (o_iso[i] || !o_pwr[i])) || (!o_iso[i] && !o_pwr[i])) begin
        mismatched++;
        $display("FAIL order dom%0d cyc=%0d got radio=%b iso=%b pwr=%b", i, n, o_radio[i], o_iso[i], o_pwr[i]);
      end
    end
  end
  task automatic cyc(input int k);
    repeat (k) @(negedge ck);
  endtask
  initial begin
    cyc(2);
    compared++;
    if ({o_busy, o_terr, o_ack, o_radio, o_iso, o_pwr} !== RST_V) begin
      mismatched++;
      $display("FAIL reset_state got %b required %b", {o_busy, o_terr, o_ack, o_radio, o_iso, o_pwr}, RST_V);
    end
    arst = 1'b0;
    pll = 1'b1; req = 2'b01; cyc(12);
    req = 2'b11; cyc(20);
    req = 2'b00; cyc(30);
    req = 2'b11; cyc(30);
    req = 2'b00; cyc(30);
    pll = 1'b0; req = 2'b10; cyc(30);
    clr = 2'b10; cyc(1); clr = 2'b00; pll = 1'b1; cyc(15);
    req = 2'b00; cyc(20);
    pll = 1'b0; req = 2'b01; cyc(8);
    req = 2'b00; cyc(15);
    pll = 1'b1; req = 2'b01; cyc(3);
    arst = 1'b1; cyc(1); arst = 1'b0; req = 2'b00; cyc(5);
    repeat (80) begin
      req = 2'($urandom);
      pll = ($urandom % 4) != 0;
      clr = ($urandom % 6 == 0) ? 2'($urandom) : 2'b00;
      cyc(1);
      clr = 2'b00;
      cyc($urandom_range(0, 14));
      if ($urandom % 40 == 0) begin arst = 1'b1; cyc(1); arst = 1'b0; end
    end
    req = 2'b00; pll = 1'b1; clr = 2'b11; cyc(1); clr = 2'b00; cyc(40);
    compared++;
    if (q.size() != 0) begin
      mismatched++;
      $display("FAIL leftover_expected got %0d pending required 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
